// File: rtl/project_select_ctrl_if.sv
// Wishbone slave bundle for the project-select control register.
// The master modport drives the request side; the slave modport answers with ack/data.
interface project_select_ctrl_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        cfg_ack_o;
   logic [31:0] cfg_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  cfg_ack_o, cfg_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output cfg_ack_o, cfg_dat_o
   );
endinterface

// File: rtl/project_select_ctrl.sv
// Selects one of several hosted user projects, gating clocks and sequencing a reset
// pulse on every switch; control comes from a Wishbone register or synchronized pins.
module project_select_ctrl #(
   parameter int unsigned USER_PROJECTS = 4,
   parameter int unsigned CFG_BITS      = $clog2(USER_PROJECTS),
   parameter logic [31:0] CFG_ADDRESS   = 32'h300FFFFC,
   parameter int unsigned RST_CYCLES    = 4
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   project_select_ctrl_if.slave     wb,
   input  logic [CFG_BITS-1:0]      pin_sel_i,
   output logic [CFG_BITS-1:0]      sel_o,
   output logic [USER_PROJECTS-1:0] clk_en_o,
   output logic [USER_PROJECTS-1:0] proj_rst_o,
   output logic                     switching_o
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_RESET} state_e;

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [CFG_BITS-1:0]      sel_q, sel_d;
   logic [CFG_BITS-1:0]      reg_sel_q, reg_sel_d;
   logic                     src_q, src_d;
   logic [CFG_BITS-1:0]      sync1_q, sync2_q;
   logic                     live_q;
   logic                     ack_q, ack_d;
   logic [31:0]              dat_q, dat_d;
   logic [USER_PROJECTS-1:0] clk_en_q, clk_en_d;
   logic [USER_PROJECTS-1:0] proj_rst_q, proj_rst_d;
   logic                     switching_q, switching_d;

   logic                     hit;
   logic [31:0]              rdata;
   logic                     pin_ok;
   logic                     target_ok;
   logic [CFG_BITS-1:0]      target;
   logic                     unused_bits;

   function automatic logic [USER_PROJECTS-1:0] onehot(input logic [CFG_BITS-1:0] idx);
      onehot = USER_PROJECTS'(1'b1) << idx;
   endfunction

   assign hit         = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i == CFG_ADDRESS);
   assign unused_bits = ^{wb.wbs_sel_i[3:2], wb.wbs_dat_i[31:9]};

   // Register access: single-cycle ack, never back to back; data snapshots pre-write state
   always_comb begin : wb_regs
      ack_d     = hit & ~ack_q;
      reg_sel_d = reg_sel_q;
      src_d     = src_q;
      rdata     = '0;
      rdata[CFG_BITS-1:0] = reg_sel_q;
      rdata[8]            = src_q;
      rdata[16]           = switching_q;
      rdata[31:24]        = 8'(USER_PROJECTS);
      if (ack_d && wb.wbs_we_i) begin
         // Whole low byte is range-checked so out-of-range writes never alias to a valid index
         if (wb.wbs_sel_i[0] && (32'(wb.wbs_dat_i[7:0]) < USER_PROJECTS)) begin
            reg_sel_d = wb.wbs_dat_i[CFG_BITS-1:0];
         end
         if (wb.wbs_sel_i[1]) begin
            src_d = wb.wbs_dat_i[8];
         end
      end
      dat_d = ack_d ? rdata : '0;
   end

   assign pin_ok    = (32'(sync2_q) < USER_PROJECTS);
   assign target    = src_q ? reg_sel_q : sync2_q;
   assign target_ok = src_q | pin_ok;

   // Switch sequencer; outputs are registered from the next-state values
   always_comb begin : fsm_next
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (target_ok && (target != sel_q)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!wb.wbs_cyc_i) begin
               if (target_ok) begin
                  sel_d = target;
               end
               cnt_d   = CNT_W'(RST_CYCLES);
               state_d = ST_RESET;
            end
         end
         ST_RESET: begin
            // First cycle after reset release holds the count so the pulse runs with clock enabled
            if (live_q) begin
               cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_RUN;
               end
            end
         end
         default: state_d = ST_RESET;
      endcase
      switching_d = (state_d != ST_RUN);
      clk_en_d    = onehot(sel_d);
      proj_rst_d  = (state_d == ST_RESET) ? '1 : ~onehot(sel_d);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= ST_RESET;
         cnt_q       <= CNT_W'(RST_CYCLES);
         sel_q       <= '0;
         reg_sel_q   <= '0;
         src_q       <= 1'b0;
         sync1_q     <= '0;
         sync2_q     <= '0;
         live_q      <= 1'b0;
         ack_q       <= 1'b0;
         dat_q       <= '0;
         clk_en_q    <= '0;
         proj_rst_q  <= '1;
         switching_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         reg_sel_q   <= reg_sel_d;
         src_q       <= src_d;
         sync1_q     <= pin_sel_i;
         sync2_q     <= sync1_q;
         live_q      <= 1'b1;
         ack_q       <= ack_d;
         dat_q       <= dat_d;
         clk_en_q    <= clk_en_d;
         proj_rst_q  <= proj_rst_d;
         switching_q <= switching_d;
      end
   end

   assign sel_o        = sel_q;
   assign clk_en_o     = clk_en_q;
   assign proj_rst_o   = proj_rst_q;
   assign switching_o  = switching_q;
   assign wb.cfg_ack_o = ack_q;
   assign wb.cfg_dat_o = dat_q;

endmodule

// File: tb/tb_project_select_ctrl.sv
// Randomized scoreboard bench for project_select_ctrl; a timeline-based reference model
// predicts every post-edge output snapshot, and a monitor compares them as they appear.
module tb_project_select_ctrl;
   localparam int unsigned UP   = 4;
   localparam int unsigned CB   = 2;
   localparam int unsigned RSTC = 4;
   localparam logic [31:0] ADDR = 32'h300FFFFC;

   logic          clk = 1'b0;
   logic          rst;
   logic [CB-1:0] pin;
   logic [CB-1:0] sel_o;
   logic [UP-1:0] clk_en;
   logic [UP-1:0] proj_rst;
   logic          sw;

   project_select_ctrl_if wb_if ();

   project_select_ctrl #(
      .USER_PROJECTS(UP), .CFG_BITS(CB), .CFG_ADDRESS(ADDR), .RST_CYCLES(RSTC)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb(wb_if), .pin_sel_i(pin),
      .sel_o(sel_o), .clk_en_o(clk_en), .proj_rst_o(proj_rst), .switching_o(sw)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CB-1:0] sel;
      logic [UP-1:0] en;
      logic [UP-1:0] prst;
      logic          sw;
      logic          ack;
      logic [31:0]   dat;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: phases 0=running, 1=draining, 2=pulsing; pulse ends at an absolute edge index
   int          m_edge;
   int          m_phase;
   int          m_pulse_end;
   bit          m_fresh;
   int          m_sel;
   int          m_regsel;
   int          m_src;
   int          m_pin_a;
   int          m_pin_b;
   bit          m_ack;
   logic [31:0] m_dat;

   function automatic void model_reset();
      m_phase = 2; m_fresh = 1'b1; m_sel = 0; m_regsel = 0; m_src = 0;
      m_pin_a = 0; m_pin_b = 0; m_ack = 1'b0; m_dat = '0; m_pulse_end = 0;
   endfunction

   function automatic exp_t model_edge();
      exp_t        e;
      int          want;
      bit          ok;
      bit          hit;
      bit          acc;
      logic [31:0] rd;
      logic [31:0] wd;
      if (rst) begin
         model_reset();
      end else begin
         m_edge = m_edge + 1;
         want = (m_src != 0) ? m_regsel : m_pin_b;
         ok   = (m_src != 0) || (m_pin_b < int'(UP));
         hit  = wb_if.wbs_cyc_i && wb_if.wbs_stb_i && (wb_if.wbs_adr_i == ADDR);
         acc  = hit && !m_ack;
         rd   = (32'(UP) << 24) | (32'(m_phase != 0) << 16) | (32'(m_src) << 8) | 32'(m_regsel);
         if (m_phase == 0) begin
            if (ok && want != m_sel) m_phase = 1;
         end else if (m_phase == 1) begin
            if (!wb_if.wbs_cyc_i) begin
               if (ok) m_sel = want;
               m_phase = 2;
               m_pulse_end = m_edge + int'(RSTC);
            end
         end else begin
            if (m_fresh) begin
               m_fresh = 1'b0;
               m_pulse_end = m_edge + int'(RSTC);
            end else if (m_edge >= m_pulse_end) begin
               m_phase = 0;
            end
         end
         if (acc && wb_if.wbs_we_i) begin
            wd = wb_if.wbs_dat_i;
            if (wb_if.wbs_sel_i[0] && (int'(wd & 32'hFF) < int'(UP))) m_regsel = int'(wd & 32'hFF);
            if (wb_if.wbs_sel_i[1]) m_src = int'((wd >> 8) & 32'h1);
         end
         m_pin_b = m_pin_a;
         m_pin_a = int'(pin);
         m_ack   = acc;
         m_dat   = acc ? rd : 32'h0;
      end
      e.sel  = CB'(m_sel);
      e.en   = m_fresh ? '0 : (UP'(1) << m_sel);
      e.prst = (m_phase == 2) ? '1 : ~(UP'(1) << m_sel);
      e.sw   = (m_phase != 0);
      e.ack  = m_ack;
      e.dat  = m_dat;
      return e;
   endfunction

   task automatic step();
      exp_q.push_back(model_edge());
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic wb_access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] be, input int hold);
      wb_if.wbs_cyc_i = 1'b1; wb_if.wbs_stb_i = 1'b1; wb_if.wbs_we_i = we;
      wb_if.wbs_adr_i = adr;  wb_if.wbs_dat_i = dat;  wb_if.wbs_sel_i = be;
      step();
      step();
      wb_if.wbs_stb_i = 1'b0; wb_if.wbs_we_i = 1'b0;
      idle(hold);
      wb_if.wbs_cyc_i = 1'b0;
      step();
   endtask

   task automatic pulse_reset(input int n);
      rst = 1'b1;
      idle(n);
      rst = 1'b0;
   endtask

   // Monitor: one snapshot per clock, sampled just after the rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (sel_o === e.sel && clk_en === e.en && proj_rst === e.prst && sw === e.sw &&
                wb_if.cfg_ack_o === e.ack && (!e.ack || wb_if.cfg_dat_o === e.dat)) begin
               n_pass++;
            end else begin
               $display("FAIL snapshot t=%0t got sel=%0d en=%b rst=%b sw=%b ack=%b dat=%h want sel=%0d en=%b rst=%b sw=%b ack=%b dat=%h",
                        $time, sel_o, clk_en, proj_rst, sw, wb_if.cfg_ack_o, wb_if.cfg_dat_o,
                        e.sel, e.en, e.prst, e.sw, e.ack, e.dat);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: stimulus did not complete in time");
      $fatal(1);
   end

   initial begin
      int r;
      rst = 1'b1; pin = '0; m_edge = 0;
      wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_stb_i = 1'b0; wb_if.wbs_we_i = 1'b0;
      wb_if.wbs_sel_i = '0;   wb_if.wbs_dat_i = '0;   wb_if.wbs_adr_i = '0;
      model_reset();
      @(negedge clk);
      idle(3);
      rst = 1'b0;
      idle(8);
      wb_access(1'b1, ADDR, 32'h0000_0102, 4'b0011, 0);
      idle(8);
      wb_access(1'b0, ADDR, 32'h0, 4'b0000, 0);
      wb_access(1'b1, ADDR, 32'h0000_0005, 4'b0001, 0);
      wb_access(1'b0, ADDR, 32'h0, 4'b0000, 0);
      idle(3);
      wb_access(1'b1, ADDR, 32'h0000_0101, 4'b0011, 10);
      idle(8);
      wb_access(1'b1, ADDR, 32'h0000_0000, 4'b0010, 0);
      idle(8);
      pin = CB'(3);
      idle(10);
      wb_access(1'b1, ADDR, 32'h0000_0102, 4'b0011, 0);
      idle(2);
      pulse_reset(2);
      idle(12);
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 3) begin
            idle(int'($urandom_range(1, 3)));
         end else if (r <= 5) begin
            wb_access(1'b1, ($urandom_range(0, 4) == 0) ? ADDR + 32'd4 : ADDR,
                      32'($urandom_range(0, 7)) | (32'($urandom_range(0, 1)) << 8),
                      4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
         end else if (r == 6) begin
            wb_access(1'b0, ADDR, 32'h0, 4'b0000, int'($urandom_range(0, 2)));
         end else if (r <= 8) begin
            pin = CB'($urandom);
            step();
         end else if ($urandom_range(0, 9) == 0) begin
            pulse_reset(int'($urandom_range(1, 2)));
         end else begin
            step();
         end
      end
      idle(int'(RSTC) + 6);
      @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d snapshots left unchecked, want 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
